// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; shifts and rotates run bit-serially.
// state | meaning: IDLE = accepts requests, single-cycle ops finish here; SHIFT = moving one bit per cycle.
module alu_seq #(
    parameter int WIDTH      = 8,
    parameter int SH_CYC_MAX = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_err
);

    localparam int CW = $clog2(SH_CYC_MAX + 1);
    localparam int XW = (WIDTH > CW) ? WIDTH : CW;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;

    localparam logic [1:0] K_SHL = 2'd0;
    localparam logic [1:0] K_SHR = 2'd1;
    localparam logic [1:0] K_ROL = 2'd2;
    localparam logic [1:0] K_ROR = 2'd3;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt;
    logic [1:0]       sh_kind;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_err;
    logic             is_shift;
    logic [1:0]       op_kind;
    logic [CW-1:0]    n_sel;
    logic [WIDTH-1:0] step_res;
    logic             step_c;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum    = {1'b0, input_a} + {1'b0, input_b};
        diff   = {1'b0, input_a} - {1'b0, input_b};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_err = 1'b0;
        case (op)
            OP_PASS: sc_res = input_a;
            OP_SUB: begin
                sc_res = diff[WIDTH-1:0];
                sc_c   = diff[WIDTH];
            end
            OP_OR:   sc_res = input_a | input_b;
            OP_XOR:  sc_res = input_a ^ input_b;
            OP_ADD: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
            end
            OP_AND:  sc_res = input_a & input_b;
            // A zero shift count completes immediately with A unchanged.
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: sc_res = input_a;
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        is_shift = 1'b0;
        op_kind  = K_SHL;
        case (op)
            OP_SHL: begin is_shift = 1'b1; op_kind = K_SHL; end
            OP_SHR: begin is_shift = 1'b1; op_kind = K_SHR; end
            OP_ROL: begin is_shift = 1'b1; op_kind = K_ROL; end
            OP_ROR: begin is_shift = 1'b1; op_kind = K_ROR; end
            default: begin is_shift = 1'b0; op_kind = K_SHL; end
        endcase
        n_sel = (XW'(input_b) >= XW'(SH_CYC_MAX)) ? CW'(SH_CYC_MAX) : CW'(input_b);
    end

    always_comb begin
        step_res = work;
        step_c   = 1'b0;
        case (sh_kind)
            K_SHL: begin
                step_res = {work[WIDTH-2:0], 1'b0};
                step_c   = work[WIDTH-1];
            end
            K_SHR: begin
                step_res = {work[WIDTH-1], work[WIDTH-1:1]};
                step_c   = work[0];
            end
            K_ROL: begin
                step_res = {work[WIDTH-2:0], work[WIDTH-1]};
                step_c   = work[WIDTH-1];
            end
            K_ROR: begin
                step_res = {work[0], work[WIDTH-1:1]};
                step_c   = work[0];
            end
            default: begin
                step_res = work;
                step_c   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            sh_kind   <= K_SHL;
            out       <= '0;
            out_valid <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
            flag_err  <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift && (n_sel != '0)) begin
                            work    <= input_a;
                            cnt     <= n_sel;
                            sh_kind <= op_kind;
                            state   <= SHIFT;
                        end else begin
                            out       <= sc_res;
                            flag_z    <= (sc_res == '0);
                            flag_c    <= sc_c;
                            flag_n    <= sc_res[WIDTH-1];
                            flag_err  <= sc_err;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work <= step_res;
                    cnt  <= cnt - CW'(1);
                    // The last step publishes directly, giving n+1 cycles of latency.
                    if (cnt == CW'(1)) begin
                        out       <= step_res;
                        flag_z    <= (step_res == '0);
                        flag_c    <= step_c;
                        flag_n    <= step_res[WIDTH-1];
                        flag_err  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: three widths (8, 16, 32) share one stimulus bus, checked
// against an arithmetic reference model of the opcode rules and latencies.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        vin, ordy;
    int          sel;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    logic        v0, v1, v2;
    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
    logic        z0, z1, z2, c0, c1, c2, n0, n1, n2, e0, e1, e2;
    logic [7:0]  o0;
    logic [15:0] o1;
    logic [31:0] o2;

    assign v0 = vin && (sel == 0);
    assign v1 = vin && (sel == 1);
    assign v2 = vin && (sel == 2);

    alu_seq #(.WIDTH(8)) u_alu8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .op(op),
        .input_a(a[7:0]), .input_b(b[7:0]), .out_valid(ov0), .out_ready(ordy),
        .out(o0), .flag_z(z0), .flag_c(c0), .flag_n(n0), .flag_err(e0));

    alu_seq #(.WIDTH(16)) u_alu16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .op(op),
        .input_a(a[15:0]), .input_b(b[15:0]), .out_valid(ov1), .out_ready(ordy),
        .out(o1), .flag_z(z1), .flag_c(c1), .flag_n(n1), .flag_err(e1));

    alu_seq #(.WIDTH(32)) u_alu32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .op(op),
        .input_a(a), .input_b(b), .out_valid(ov2), .out_ready(ordy),
        .out(o2), .flag_z(z2), .flag_c(c2), .flag_n(n2), .flag_err(e2));

    logic        obs_rdy, obs_ov, obs_z, obs_c, obs_n, obs_e;
    logic [31:0] obs_out;

    always_comb begin
        obs_rdy = rdy0; obs_ov = ov0; obs_out = {24'b0, o0};
        obs_z = z0; obs_c = c0; obs_n = n0; obs_e = e0;
        if (sel == 1) begin
            obs_rdy = rdy1; obs_ov = ov1; obs_out = {16'b0, o1};
            obs_z = z1; obs_c = c1; obs_n = n1; obs_e = e1;
        end else if (sel == 2) begin
            obs_rdy = rdy2; obs_ov = ov2; obs_out = o2;
            obs_z = z2; obs_c = c2; obs_n = n2; obs_e = e2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 0) ? 8 : (s == 1) ? 16 : 32;
    endfunction

    // Reference: results from plain arithmetic on the opcode definitions.
    function automatic void model(input int w, input logic [3:0] o,
                                  input logic [31:0] xa, input logic [31:0] xb,
                                  output logic [31:0] r, output logic c,
                                  output logic e, output int lat);
        logic [63:0] m, aa, bb, s, rr;
        logic signed [63:0] sx;
        int nn, k;
        m  = (64'd1 << w) - 64'd1;
        aa = {32'b0, xa} & m;
        bb = {32'b0, xb} & m;
        rr = 64'd0;
        c  = 1'b0;
        e  = 1'b0;
        lat = 1;
        nn = (bb > 64'(w)) ? w : int'(bb);
        case (o)
            4'd0: rr = aa;
            4'd1: begin rr = (aa - bb) & m; c = (aa < bb); end
            4'd2: rr = aa | bb;
            4'd3: rr = aa ^ bb;
            4'd4: begin s = aa + bb; rr = s & m; c = s[w]; end
            4'd7: rr = aa & bb;
            4'd5, 4'd6, 4'd8, 4'd9: begin
                lat = nn + 1;
                if (nn == 0) rr = aa;
                else begin
                    k = nn % w;
                    case (o)
                        4'd5: begin rr = (aa << nn) & m; c = aa[w-nn]; end
                        4'd6: begin
                            sx = $signed(aa[w-1] ? (aa | ~m) : aa);
                            rr = 64'(sx >>> nn) & m;
                            c  = aa[nn-1];
                        end
                        4'd8: begin
                            rr = (k == 0) ? aa : (((aa << k) | (aa >> (w - k))) & m);
                            c  = rr[0];
                        end
                        default: begin
                            rr = (k == 0) ? aa : (((aa >> k) | (aa << (w - k))) & m);
                            c  = rr[w-1];
                        end
                    endcase
                end
            end
            default: e = 1'b1;
        endcase
        r = rr[31:0];
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb);
        int g = 0;
        while (!obs_rdy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("rdy_timeout", 32'd0, 32'd1);
        op = o; a = xa; b = xb; vin = 1'b1;
        @(posedge clk);
        #1 vin = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!obs_ov && lat < 200);
        if (!obs_ov) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb);
        logic [31:0] r;
        logic c, e;
        int lat_exp, lat_got, w;
        w = width_of(sel);
        model(w, o, xa, xb, r, c, e, lat_exp);
        issue(o, xa, xb);
        wait_result(lat_got);
        chk({tag, "_lat"}, lat_got, lat_exp);
        chk({tag, "_out"}, obs_out, r);
        chk({tag, "_z"}, {31'b0, obs_z}, {31'b0, r == 32'd0});
        chk({tag, "_c"}, {31'b0, obs_c}, {31'b0, c});
        chk({tag, "_n"}, {31'b0, obs_n}, {31'b0, r[w-1]});
        chk({tag, "_err"}, {31'b0, obs_e}, {31'b0, e});
    endtask

    initial begin
        logic [31:0] r, amt;
        logic c, e, seen;
        int lat, w;
        logic [3:0] q_op[8];
        logic [31:0] q_a[8], q_b[8], q_r[8];

        rst_n = 1'b1; vin = 1'b0; ordy = 1'b1; op = 4'd0; a = '0; b = '0; sel = 0;
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst_ov_w%0d", width_of(s)), {31'b0, obs_ov}, 32'd0);
            chk($sformatf("rst_out_w%0d", width_of(s)), obs_out, 32'd0);
            chk($sformatf("rst_flags_w%0d", width_of(s)), {28'b0, obs_z, obs_c, obs_n, obs_e}, 32'd0);
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_rdy", {31'b0, obs_rdy}, 32'd1);

        run("add", 4'd4, 32'hF0, 32'h20);
        chk("add_const", obs_out, 32'h10);
        run("sub_eq", 4'd1, 32'h05, 32'h05);
        chk("sub_eq_z", {31'b0, obs_z}, 32'd1);
        run("sub_borrow", 4'd1, 32'h03, 32'h04);
        chk("sub_borrow_const", obs_out, 32'hFF);
        run("shr3", 4'd6, 32'h90, 32'd3);
        chk("shr3_const", obs_out, 32'hF2);
        run("shl1", 4'd5, 32'h81, 32'd1);
        chk("shl1_const", obs_out, 32'h02);
        run("shl200", 4'd5, 32'h81, 32'd200);
        chk("shl200_const", obs_out, 32'h00);
        run("rol1", 4'd8, 32'h81, 32'd1);
        chk("rol1_const", obs_out, 32'h03);
        run("illegal", 4'hC, 32'h5A, 32'h33);
        chk("illegal_err", {31'b0, obs_e}, 32'd1);

        // Reset in the middle of a serial shift.
        issue(4'd5, 32'h01, 32'd5);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out", obs_out, 32'd0);
        chk("midrst_ov", {31'b0, obs_ov}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_rdy", {31'b0, obs_rdy}, 32'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (obs_ov) seen = 1'b1;
        end
        chk("midrst_no_stale", {31'b0, seen}, 32'd0);

        // Backpressure, then drain and accept in the same cycle.
        ordy = 1'b0;
        issue(4'd4, 32'h12, 32'h34);
        wait_result(lat);
        model(8, 4'd4, 32'h12, 32'h34, r, c, e, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp_rdy_%0d", i), {31'b0, obs_rdy}, 32'd0);
            chk($sformatf("bp_ov_%0d", i), {31'b0, obs_ov}, 32'd1);
            chk($sformatf("bp_out_%0d", i), obs_out, r);
            chk($sformatf("bp_flags_%0d", i), {28'b0, obs_z, obs_c, obs_n, obs_e}, 32'd0);
        end
        ordy = 1'b1; op = 4'd3; a = 32'hAA; b = 32'hFF; vin = 1'b1;
        #1 chk("bp_drain_rdy", {31'b0, obs_rdy}, 32'd1);
        @(posedge clk);
        #1 vin = 1'b0;
        wait_result(lat);
        chk("bp_xor_lat", lat, 32'd1);
        chk("bp_xor_out", obs_out, 32'h55);

        // Back-to-back single-cycle ops: one result per cycle, in order.
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 6))
                0: q_op[i] = 4'd0; 1: q_op[i] = 4'd1; 2: q_op[i] = 4'd2;
                3: q_op[i] = 4'd3; 4: q_op[i] = 4'd4; 5: q_op[i] = 4'd7;
                default: q_op[i] = 4'hE;
            endcase
            q_a[i] = $urandom;
            q_b[i] = $urandom;
            model(8, q_op[i], q_a[i], q_b[i], r, c, e, lat);
            q_r[i] = r;
        end
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("b2b_ov_%0d", i - 1), {31'b0, obs_ov}, 32'd1);
                chk($sformatf("b2b_out_%0d", i - 1), obs_out, q_r[i-1]);
            end
            if (i < 8) begin
                chk($sformatf("b2b_rdy_%0d", i), {31'b0, obs_rdy}, 32'd1);
                op = q_op[i]; a = q_a[i]; b = q_b[i]; vin = 1'b1;
            end else vin = 1'b0;
        end

        // Regression over all widths: boundary shift counts and random ops.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            w = width_of(s);
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 5; j++) begin
                    case (j)
                        0: amt = 32'd0;
                        1: amt = 32'd1;
                        2: amt = 32'(w - 1);
                        3: amt = 32'(w);
                        default: amt = 32'hFFFF_FFFF;
                    endcase
                    run($sformatf("w%0d_sh%0d_n%0d", w, k, j),
                        (k == 0) ? 4'd5 : (k == 1) ? 4'd6 : (k == 2) ? 4'd8 : 4'd9,
                        $urandom, amt);
                end
            end
            for (int i = 0; i < 30; i++) begin
                op = 4'($urandom_range(0, 15));
                amt = (op == 4'd5 || op == 4'd6 || op == 4'd8 || op == 4'd9)
                      ? 32'($urandom_range(0, w + 2)) : $urandom;
                run($sformatf("w%0d_rnd%0d", w, i), op, $urandom, amt);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational datapath ALU.
- Adds a generic WIDTH, new opcodes, status flags, and a valid/ready handshake on both input and output.
- Shifts and rotates run as a bit-serial multi-cycle operation to save area.
- Sits between the register-file read stage and the writeback stage of the core.

Parameters:
WIDTH, 8, datapath width in bits (>= 2)
SH_CYC_MAX, WIDTH, cap on the serial shift count; the effective count is min(INPUT_B, SH_CYC_MAX)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  operation request
IN_READY  out  1  block accepts a request this cycle
OP  in  4  opcode
INPUT_A  in  WIDTH  operand A
INPUT_B  in  WIDTH  operand B, or the shift amount
OUT_VALID  out  1  result held on OUT
OUT_READY  in  1  consumer takes the result
OUT  out  WIDTH  registered result
FLAG_Z  out  1  OUT == 0
FLAG_C  out  1  carry, borrow, or last bit shifted out
FLAG_N  out  1  OUT[WIDTH-1]
FLAG_ERR  out  1  illegal opcode

Behaviour:
- Reset (async, RST_N=0): state=IDLE; OUT=0; OUT_VALID=0; all flags=0. Any in-flight operation is discarded.
- Handshake:
  - A transfer occurs when IN_VALID && IN_READY at a rising edge of CLK.
  - IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY), so a held result can drain and a new request be accepted in the same cycle.
  - OUT, flags and OUT_VALID stay stable while OUT_VALID && !OUT_READY.
  - OUT_VALID clears on OUT_READY unless a new result loads in that same cycle.
- Opcodes: 0 PASS A; 1 SUB A-B; 2 OR; 3 XOR; 4 ADD; 5 SHL logical; 6 SHR arithmetic (sign fill); 7 AND; 8 ROL; 9 ROR; 10-15 illegal.
- Single-cycle ops (0-4, 7, illegal):
  - Result and flags are registered at the accept edge; OUT_VALID=1 the following cycle (latency 1).
- Illegal opcode: OUT=0, FLAG_ERR=1, FLAG_Z=1, C=0, N=0.
- Arithmetic is modulo 2^WIDTH.
- ADD: C = carry out of bit WIDTH-1.
- SUB: C = borrow (A < B, unsigned).
- Logic ops and PASS: C=0.
- Shift/rotate ops (5, 6, 8, 9):
  - n = min(INPUT_B unsigned, SH_CYC_MAX), latched at accept.
  - n=0: behaves as a single-cycle op, OUT=A, C=0.
  - n>0: state IDLE->SHIFT, with A held in a working register; one bit position per cycle; a down-counter from n.
  - When the counter reaches 0: load OUT and flags, set OUT_VALID, return to IDLE.
  - Latency is n+1 cycles from the accept edge to OUT_VALID.
  - C = the last bit moved out (SHL: bit WIDTH-1; SHR: bit 0; ROL/ROR: the bit that wrapped).
  - SHL with n>=WIDTH gives 0. SHR with n>=WIDTH gives all sign bits. Rotates by n wrap modulo WIDTH naturally.
  - IN_READY=0 throughout SHIFT.
- Flags: FLAG_Z and FLAG_N are computed from the final result and are registered alongside OUT.
- FLAG_ERR=0 for legal opcodes.
- No request is dropped or duplicated. When IN_VALID=0, state is unchanged apart from the output drain.

Test Plan:
- Reset: RST_N low mid-SHIFT (SHL A=8'h01, B=5, after 2 cycles) -> immediately OUT=0, OUT_VALID=0, IN_READY=1 after release; no stale result appears.
- WIDTH=8, ADD A=8'hF0, B=8'h20 -> one cycle later OUT=8'h10, C=1, Z=0, N=0. SUB A=8'h05, B=8'h05 -> OUT=0, Z=1, C=0. SUB A=8'h03, B=8'h04 -> OUT=8'hFF, C=1, N=1.
- SHR A=8'h90, B=3 -> OUT_VALID exactly 4 cycles after accept, OUT=8'hF2, C=0. SHL A=8'h81, B=1 -> latency 2, OUT=8'h02, C=1. SHL B=8'd200 -> latency 9, OUT=0. ROL A=8'h81, B=1 -> OUT=8'h03, C=1.
- Backpressure: hold OUT_READY=0 with a result pending -> IN_READY=0 and OUT/flags stable for 10 cycles. Raise OUT_READY with IN_VALID=1, XOR 8'hAA^8'hFF -> drain and accept in the same cycle; next OUT=8'h55.
- Back-to-back single-cycle ops with OUT_READY=1 -> one result per cycle, in order, no bubbles. OP=4'hC -> OUT=0, ERR=1, Z=1.
- Regression with WIDTH=16 and WIDTH=32: random operands against a reference model, plus shift amounts 0, 1, WIDTH-1, WIDTH and max -> all results, flags and latencies match.
